router_ingress_fifo: RTL and testbench

Ingress queue placed directly upstream of the 4-way simple router. It accepts {destination address, data} words from a producer and buffers them in a DEPTH-entry FIFO. It then issues them one per cycle, on downstream permission, as a registered data/enable/address triple that connects directly to the router's din/din_en/addr inputs. Overflowed writes are dropped and counted.

---
 rtl/router_ingress_fifo.sv | 116 +++++++++++
 tb/tb_router_ingress_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_ingress_fifo.sv
// Ingress queue in front of the 4-way router. Buffers {addr, data} words in a
// circular buffer and issues one per cycle on rd_ready as a registered
// din/din_en/addr triple. Writes that arrive while full (with no pop) are
// dropped and counted in a saturating counter.
module router_ingress_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int DROP_W     = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [1:0]              wr_addr,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_en,
    output logic [1:0]              out_addr,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DROP_W-1:0]       drop_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + 2;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [ENTRY_W-1:0]    head_p0;
    logic                  push;
    logic                  pop;
    logic                  drop;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [1:0]            addr_p1;
    logic [DROP_W-1:0]     drop_cnt_q;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign head_p0 = mem[rd_ptr];

    // A pop needs a stored entry, so a word written this edge cannot also
    // be popped this edge (no bypass). A full FIFO still accepts a write
    // when the same edge pops, since a slot frees up.
    assign pop  = rd_ready && (cnt != '0);
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    // Storage array: payload only, no reset; validity is tracked by the
    // pointers and count, so stale contents are never issued.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_addr, wr_data};
        end
    end

    // Pointers, occupancy and drop counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (drop) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
        end
    end

    // Output register: loads the head entry on a pop, otherwise drives
    // zeros so the router sees quiet lines when idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            addr_p1 <= '0;
        end else if (pop) begin
            vld_p1  <= 1'b1;
            data_p1 <= head_p0[DATA_WIDTH-1:0];
            addr_p1 <= head_p0[ENTRY_W-1 -: 2];
        end else begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            addr_p1 <= '0;
        end
    end

    assign out_en   = vld_p1;
    assign out_data = data_p1;
    assign out_addr = addr_p1;
    assign count    = cnt;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_router_ingress_fifo.sv
module tb_router_ingress_fifo;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [1:0]  wr_addr;
    logic        rd_ready;
    logic [31:0] out_data;
    logic        out_en;
    logic [1:0]  out_addr;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [33:0] sb[$];
    logic [33:0] obs[$];

    router_ingress_fifo #(
        .DATA_WIDTH(32),
        .DEPTH     (4),
        .DROP_W    (8)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_addr (wr_addr),
        .rd_ready(rd_ready),
        .out_data(out_data),
        .out_en  (out_en),
        .out_addr(out_addr),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge, sample 1 time unit later, record any issued word.
    task automatic step();
        @(posedge clk);
        #1;
        if (out_en === 1'b1) obs.push_back({out_addr, out_data});
    endtask

    task automatic test_reset();
        resetn = 1'b0; wr_en = 1'b0; rd_ready = 1'b0; wr_data = '0; wr_addr = '0;
        repeat (3) step();
        resetn = 1'b1;
        step(); step();
        n_tests++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL reset_out_en got %b want 0", out_en); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_tests++; if (out_addr !== 2'd0) begin n_fail++; $display("FAIL reset_out_addr got %0d want 0", out_addr); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        obs.delete(); sb.delete();
    endtask

    task automatic test_single();
        logic [33:0] got, exp;
        rd_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'hA5A5_0001;
        sb.push_back({2'd2, 32'hA5A5_0001});
        step();
        wr_en = 1'b0;
        n_tests++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass out_en got %b want 0", out_en); end
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count_after_push got %0d want 1", count); end
        step();
        n_tests++; if (out_en !== 1'b1) begin n_fail++; $display("FAIL single_pulse out_en got %b want 1", out_en); end
        step();
        n_tests++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width out_en got %b want 0", out_en); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count_final got %0d want 0", count); end
        n_tests++; if (obs.size() != 1) begin n_fail++; $display("FAIL single_pulses got %0d want 1", obs.size()); end
        while (obs.size() > 0 && sb.size() > 0) begin
            got = obs.pop_front(); exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL single_word got %h want %h", got, exp); end
        end
        obs.delete(); sb.delete();
    endtask

    task automatic test_overflow();
        logic [33:0] got, exp;
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = 32'h10 + 32'(i);
            sb.push_back({2'(i), 32'h10 + 32'(i)});
            step();
        end
        wr_addr = 2'd0; wr_data = 32'h14;
        step();
        wr_en = 1'b0;
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", full); end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", count); end
        n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
        rd_ready = 1'b1;
        repeat (6) step();
        n_tests++; if (obs.size() != 4) begin n_fail++; $display("FAIL ovf_pulses got %0d want 4", obs.size()); end
        while (obs.size() > 0 && sb.size() > 0) begin
            got = obs.pop_front(); exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL ovf_order got %h want %h", got, exp); end
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained empty got %b want 1", empty); end
        obs.delete(); sb.delete();
    endtask

    task automatic test_full_simul();
        logic [33:0] got, exp;
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(3 - i); wr_data = 32'h30 + 32'(i);
            sb.push_back({2'(3 - i), 32'h30 + 32'(i)});
            step();
        end
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h20; rd_ready = 1'b1;
        sb.push_back({2'd1, 32'h20});
        step();
        wr_en = 1'b0;
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL simul_count got %0d want 4", count); end
        n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL simul_drop_cnt got %0d want 1", drop_cnt); end
        n_tests++; if (obs.size() != 1) begin n_fail++; $display("FAIL simul_first_issue got %0d want 1", obs.size()); end
        repeat (7) step();
        n_tests++; if (obs.size() != 5) begin n_fail++; $display("FAIL simul_pulses got %0d want 5", obs.size()); end
        while (obs.size() > 0 && sb.size() > 0) begin
            got = obs.pop_front(); exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL simul_order got %h want %h", got, exp); end
        end
        obs.delete(); sb.delete();
    endtask

    task automatic test_toggle();
        logic [33:0] got, exp;
        int  occ;
        int  idx;
        logic rd, can_pop, do_push;
        occ = 0; idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
            rd      = (cyc % 2 == 0);
            can_pop = rd && (occ > 0);
            do_push = (occ < 4) || can_pop;
            rd_ready = rd;
            wr_en    = do_push;
            wr_addr  = 2'(idx % 4);
            wr_data  = 32'h40 + 32'(idx);
            if (do_push) begin
                sb.push_back({2'(idx % 4), 32'h40 + 32'(idx)});
                idx++;
            end
            step();
            occ = occ + (do_push ? 1 : 0) - (can_pop ? 1 : 0);
            n_tests++;
            if (count !== 3'(occ)) begin n_fail++; $display("FAIL toggle_count cyc %0d got %0d want %0d", cyc, count, occ); end
        end
        n_tests++; if (idx != 10) begin n_fail++; $display("FAIL toggle_pushed got %0d want 10", idx); end
        wr_en = 1'b0; rd_ready = 1'b1;
        repeat (8) step();
        n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL toggle_drop_cnt got %0d want 1", drop_cnt); end
        n_tests++; if (obs.size() != 10) begin n_fail++; $display("FAIL toggle_pulses got %0d want 10", obs.size()); end
        while (obs.size() > 0 && sb.size() > 0) begin
            got = obs.pop_front(); exp = sb.pop_front();
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL toggle_order got %h want %h", got, exp); end
        end
        obs.delete(); sb.delete();
    endtask

    task automatic test_async_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = 32'h50 + 32'(i);
            step();
        end
        wr_en = 1'b0; rd_ready = 1'b1;
        step();
        n_tests++; if (out_en !== 1'b1) begin n_fail++; $display("FAIL areset_pre_out_en got %b want 1", out_en); end
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL areset_pre_count got %0d want 3", count); end
        obs.delete(); sb.delete();
        #1;
        resetn = 1'b0;
        #1;
        n_tests++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL areset_out_en got %b want 0", out_en); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL areset_out_data got %h want 0", out_data); end
        n_tests++; if (out_addr !== 2'd0) begin n_fail++; $display("FAIL areset_out_addr got %0d want 0", out_addr); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL areset_count got %0d want 0", count); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL areset_empty got %b want 1", empty); end
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) step();
        n_tests++; if (obs.size() != 0) begin n_fail++; $display("FAIL areset_stale got %0d pulses want 0", obs.size()); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL areset_post_count got %0d want 0", count); end
        obs.delete(); sb.delete();
    endtask

    task automatic test_drop_sat();
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = 32'h60 + 32'(i);
            step();
        end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_start got %0d want 0", drop_cnt); end
        for (int i = 0; i < 300; i++) begin
            wr_data = 32'h100 + 32'(i);
            step();
            if (i == 253) begin
                n_tests++;
                if (drop_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d want 254", drop_cnt); end
            end
            if (i == 254) begin
                n_tests++;
                if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d want 255", drop_cnt); end
            end
        end
        wr_en = 1'b0;
        n_tests++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", drop_cnt); end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL sat_count got %0d want 4", count); end
        obs.delete(); sb.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_simul();
        test_toggle();
        test_async_reset();
        test_drop_sat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
